spi_pkt: RTL and testbench

- Serial-to-parallel byte packer on the SPI receive path.
- Samples one bit of `din` per clock while `en` is high and assembles the bits into a DATA_W-bit word, MSB first by default.
- On each completed word, presents it on `dout` and pulses `byte_flg` for one cycle to the downstream packet logic.

---
 rtl/spi_pkt.sv | 82 ++++++++
 tb/tb_spi_pkt.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/spi_pkt.sv
// spi_pkt: serial-to-parallel packer for the SPI receive path.
// One bit of din is taken per clock while en is high. Every DATA_W bits the
// assembled word is presented on dout and byte_flg pulses for one cycle.
// Dropping en, or asserting the active-low rst, throws away any partial word.
module spi_pkt #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              en,
  output logic [DATA_W-1:0] dout,
  output logic              byte_flg
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-2:0] r_sr;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_dout;
  logic              r_flg;

  logic [DATA_W-2:0] w_sr_shift;
  logic [DATA_W-1:0] w_word;
  logic              w_last;

  // The DATA_W-th bit of a word is being sampled in this cycle.
  assign w_last = (r_cnt == CNT_W'(DATA_W - 1));

  // Bit ordering is fixed at elaboration time. With DATA_W=2 the shift
  // register holds only one bit, so the shift is just a load of din.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_word = {r_sr, din};
      if (DATA_W == 2) begin : g_w2
        assign w_sr_shift = din;
      end else begin : g_wn
        assign w_sr_shift = {r_sr[DATA_W-3:0], din};
      end
    end else begin : g_lsb
      assign w_word = {din, r_sr};
      if (DATA_W == 2) begin : g_w2
        assign w_sr_shift = din;
      end else begin : g_wn
        assign w_sr_shift = {din, r_sr[DATA_W-2:1]};
      end
    end
  endgenerate

  // Shift in bits, publish completed words, and pulse the word flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_dout <= '0;
      r_flg  <= 1'b0;
    end else if (en) begin
      if (w_last) begin
        // The word is complete. Clearing sr and cnt here lets the next
        // bit start a new word with no idle cycle in between.
        r_dout <= w_word;
        r_flg  <= 1'b1;
        r_cnt  <= '0;
        r_sr   <= '0;
      end else begin
        r_sr   <= w_sr_shift;
        r_cnt  <= r_cnt + 1'b1;
        r_flg  <= 1'b0;
      end
    end else begin
      // Idle or frame abort: drop the partial word and keep dout as it is.
      r_sr   <= '0;
      r_cnt  <= '0;
      r_flg  <= 1'b0;
    end
  end

  assign dout     = r_dout;
  assign byte_flg = r_flg;

endmodule

// File: tb/tb_spi_pkt.sv
// tb_spi_pkt: bench for spi_pkt.
// It runs three instances: 8-bit MSB-first, 8-bit LSB-first and 5-bit
// LSB-first. The stimulus is a directed vector table, a check of the pulse
// spacing for back-to-back words, and a randomized run compared against a
// word-level reference model.
module tb_spi_pkt;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b0;
  logic       en  = 1'b0;
  logic [7:0] dout_m, dout_l;
  logic [4:0] dout_5;
  logic       flg_m, flg_l, flg_5;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_pkt #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .en(en), .dout(dout_m), .byte_flg(flg_m));
  spi_pkt #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .en(en), .dout(dout_l), .byte_flg(flg_l));
  spi_pkt #(.DATA_W(5), .MSB_FIRST(1'b0)) dut_5 (
    .clk(clk), .rst(rst), .din(din), .en(en), .dout(dout_5), .byte_flg(flg_5));

  // Reference model. It keeps the list of bits received so far for each
  // instance and builds the whole word from that list once it is full.
  int          mw  [3] = '{8, 8, 5};
  bit          mmsb[3] = '{1'b1, 1'b0, 1'b0};
  logic        mbits[3][32];
  int          mn  [3];
  logic [31:0] exp_dout[3];
  logic        exp_flg [3];

  task automatic model_step(input logic r, input logic e, input logic d);
    logic [31:0] word;
    for (int k = 0; k < 3; k++) begin
      if (!r) begin
        mn[k] = 0; exp_dout[k] = '0; exp_flg[k] = 1'b0;
      end else if (e) begin
        mbits[k][mn[k]] = d;
        mn[k]++;
        exp_flg[k] = 1'b0;
        if (mn[k] == mw[k]) begin
          word = '0;
          for (int i = 0; i < mw[k]; i++) begin
            if (mmsb[k]) word = word + (32'(mbits[k][i]) << (mw[k] - 1 - i));
            else         word = word + (32'(mbits[k][i]) << i);
          end
          exp_dout[k] = word;
          exp_flg[k]  = 1'b1;
          mn[k]       = 0;
        end
      end else begin
        mn[k] = 0; exp_flg[k] = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Apply one cycle of input, advance the model, and return to a point 1 time
  // unit after the rising edge so the outputs can be sampled.
  task automatic step(input logic r, input logic e, input logic d);
    rst = r; en = e; din = d;
    @(posedge clk);
    model_step(r, e, d);
    #1;
  endtask

  typedef struct {
    logic       r, e, d;
    logic [7:0] m, l;
    logic       f;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic d,
                     input logic [7:0] m, input logic [7:0] l, input logic f);
    vec_t v;
    v.r = r; v.e = e; v.d = d; v.m = m; v.l = l; v.f = f;
    tbl.push_back(v);
  endtask

  // Adds 8 bits of v, first bit v[7]. dout holds hm/hl until the last bit,
  // which produces m/l together with one pulse.
  task automatic add_byte(input logic [7:0] v, input logic [7:0] hm, input logic [7:0] hl,
                          input logic [7:0] m, input logic [7:0] l);
    for (int i = 7; i >= 0; i--)
      add(1'b1, 1'b1, v[i], (i == 0) ? m : hm, (i == 0) ? l : hl, i == 0);
  endtask

  initial begin
    int pulse_t[$];
    int cyc;
    logic [3:0] part;

    // Directed vectors; expected values are worked out from the bit-order rules.
    add(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);          // reset held, din toggling
    add(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    add_byte(8'hAB, 8'h00, 8'h00, 8'hAB, 8'hD5);        // first byte after release
    add_byte(8'hCC, 8'hAB, 8'hD5, 8'hCC, 8'h33);        // back-to-back byte
    for (int i = 0; i < 5; i++) add(1'b1, 1'b1, 1'b1, 8'hCC, 8'h33, 1'b0); // partial word
    add(1'b1, 1'b0, 1'b1, 8'hCC, 8'h33, 1'b0);          // abort
    add_byte(8'hF0, 8'hCC, 8'h33, 8'hF0, 8'h0F);
    add(1'b1, 1'b0, 1'b0, 8'hF0, 8'h0F, 1'b0);          // idle: pulse ends
    part = 4'b1010;
    for (int i = 3; i >= 0; i--) add(1'b1, 1'b1, part[i], 8'hF0, 8'h0F, 1'b0);
    add(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);          // reset mid-word
    add_byte(8'h5A, 8'h00, 8'h00, 8'h5A, 8'h5A);
    add(1'b1, 1'b0, 1'b0, 8'h5A, 8'h5A, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].d);
      $display("vec %0d: rst=%0b en=%0b din=%0b -> dout_m=%02h dout_l=%02h flg=%0b/%0b",
               i, tbl[i].r, tbl[i].e, tbl[i].d, dout_m, dout_l, flg_m, flg_l);
      check($sformatf("vec%0d dout_msb", i), 32'(dout_m), 32'(tbl[i].m));
      check($sformatf("vec%0d flg_msb", i),  32'(flg_m),  32'(tbl[i].f));
      check($sformatf("vec%0d dout_lsb", i), 32'(dout_l), 32'(tbl[i].l));
      check($sformatf("vec%0d flg_lsb", i),  32'(flg_l),  32'(tbl[i].f));
    end

    // Pulse spacing: 24 bits with en held high must give 3 pulses, 8 cycles apart.
    step(1'b0, 1'b0, 1'b0);
    cyc = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      cyc++;
      if (flg_m) pulse_t.push_back(cyc);
    end
    step(1'b1, 1'b0, 1'b0);
    $display("spacing: %0d pulses over 24 bits", pulse_t.size());
    check("pulse_count", 32'(pulse_t.size()), 32'd3);
    if (pulse_t.size() == 3) begin
      check("first_pulse_cycle", 32'(pulse_t[0]), 32'd8);
      check("pulse_gap_1", 32'(pulse_t[1] - pulse_t[0]), 32'd8);
      check("pulse_gap_2", 32'(pulse_t[2] - pulse_t[1]), 32'd8);
    end

    // Randomized run checked against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
           ($urandom_range(0, 99) < 90) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)));
      if (flg_m || flg_l || flg_5)
        $display("rnd %0d: dout_m=%02h dout_l=%02h dout_5=%02h flg=%0b%0b%0b",
                 i, dout_m, dout_l, dout_5, flg_m, flg_l, flg_5);
      check("rnd dout_msb8", 32'(dout_m), exp_dout[0]);
      check("rnd flg_msb8",  32'(flg_m),  32'(exp_flg[0]));
      check("rnd dout_lsb8", 32'(dout_l), exp_dout[1]);
      check("rnd flg_lsb8",  32'(flg_l),  32'(exp_flg[1]));
      check("rnd dout_lsb5", 32'(dout_5), exp_dout[2]);
      check("rnd flg_lsb5",  32'(flg_5),  32'(exp_flg[2]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
